bcd_counter_bank: RTL and testbench

Multi-digit BCD event counter fed directly by the debounced trigger/pulse stage. It consumes that stage's inc_clk and ref_clk pulses plus the per-digit trigger levels. On each inc_clk it adds 1 to every digit whose trigger is high, rippling carries one digit per clock. On ref_clk it copies the settled count into a display register that drives the seven-segment/output stage.

---
 rtl/bcd_counter_bank_if.sv | 22 ++
 rtl/bcd_counter_bank.sv | 108 ++++++++++
 tb/tb_bcd_counter_bank.sv | 207 ++++++++++++++++++++
 3 files changed

// File: rtl/bcd_counter_bank_if.sv
// Bus bundle between the trigger/pulse stage and the BCD counter bank.
// master drives strobes and trigger levels; slave is the counter bank.
interface bcd_counter_bank_if #(
    parameter int unsigned DIGITS = 6
);
    logic [DIGITS-1:0]   trigger;
    logic                inc_clk;
    logic                ref_clk;
    logic [4*DIGITS-1:0] count_out;
    logic                busy;
    logic                overflow;

    modport master (
        output trigger, inc_clk, ref_clk,
        input  count_out, busy, overflow
    );

    modport slave (
        input  trigger, inc_clk, ref_clk,
        output count_out, busy, overflow
    );
endinterface

// File: rtl/bcd_counter_bank.sv
// Multi-digit BCD event counter: per-digit increments ripple one digit per clock,
// and the settled count is copied to a display register on refresh strobes.
module bcd_counter_bank #(
    parameter int unsigned DIGITS = 6
) (
    input  logic              clk,
    input  logic              reset,
    bcd_counter_bank_if.slave bus
);
    localparam int unsigned IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;

    typedef enum logic {IDLE, RIPPLE} state_t;

    state_t                   state,     state_nxt;
    logic [DIGITS-1:0][3:0]   count,     count_nxt;
    logic [4*DIGITS-1:0]      disp,      disp_nxt;
    logic [DIGITS-1:0]        pending,   pending_nxt;
    logic                     carry,     carry_nxt;
    logic [IDX_W-1:0]         index,     index_nxt;
    logic                     busy,      busy_nxt;
    logic                     overflow,  overflow_nxt;
    logic                     defer,     defer_nxt;
    logic [3:0]               sum;

    // State register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= IDLE;
            count    <= '0;
            disp     <= '0;
            pending  <= '0;
            carry    <= 1'b0;
            index    <= '0;
            busy     <= 1'b0;
            overflow <= 1'b0;
            defer    <= 1'b0;
        end else begin
            state    <= state_nxt;
            count    <= count_nxt;
            disp     <= disp_nxt;
            pending  <= pending_nxt;
            carry    <= carry_nxt;
            index    <= index_nxt;
            busy     <= busy_nxt;
            overflow <= overflow_nxt;
            defer    <= defer_nxt;
        end
    end

    // Next-state and datapath
    always_comb begin
        state_nxt    = state;
        count_nxt    = count;
        disp_nxt     = disp;
        pending_nxt  = pending;
        carry_nxt    = carry;
        index_nxt    = index;
        busy_nxt     = busy;
        overflow_nxt = overflow;
        defer_nxt    = defer;
        sum          = 4'd0;

        case (state)
            IDLE: begin
                // Refresh samples the pre-increment count even if inc_clk arrives together
                if (bus.ref_clk || defer) begin
                    disp_nxt  = count;
                    defer_nxt = 1'b0;
                end
                if (bus.inc_clk) begin
                    pending_nxt = bus.trigger;
                    carry_nxt   = 1'b0;
                    index_nxt   = '0;
                    busy_nxt    = 1'b1;
                    state_nxt   = RIPPLE;
                end
            end
            RIPPLE: begin
                if (bus.ref_clk) begin
                    defer_nxt = 1'b1;
                end
                // Max 9+1+1 = 11, fits in 4 bits
                sum = count[index] + 4'(pending[index]) + 4'(carry);
                if (sum > 4'd9) begin
                    count_nxt[index] = sum - 4'd10;
                    carry_nxt        = 1'b1;
                end else begin
                    count_nxt[index] = sum;
                    carry_nxt        = 1'b0;
                end
                if (index == IDX_W'(DIGITS - 1)) begin
                    state_nxt = IDLE;
                    busy_nxt  = 1'b0;
                    if (carry_nxt) begin
                        overflow_nxt = 1'b1;
                    end
                end else begin
                    index_nxt = index + 1'b1;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    assign bus.count_out = disp;
    assign bus.busy      = busy;
    assign bus.overflow  = overflow;
endmodule

// File: tb/tb_bcd_counter_bank.sv
// Directed self-checking bench for bcd_counter_bank (DIGITS = 6).
// Expected counts are written as hex literals, which read directly as BCD.
module tb_bcd_counter_bank;
    localparam int unsigned DIGITS = 6;

    logic clk;
    logic reset;
    int   n_cmp;
    int   n_err;

    bcd_counter_bank_if #(.DIGITS(DIGITS)) bus ();

    bcd_counter_bank #(.DIGITS(DIGITS)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [5:0]  trig;
        logic [23:0] exp_count;
    } vec_t;

    vec_t vecs [6];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        step();
        reset = 1'b0;
        step();
    endtask

    task automatic strobe_inc(input logic [5:0] trig);
        bus.trigger = trig;
        bus.inc_clk = 1'b1;
        step();
        bus.inc_clk = 1'b0;
    endtask

    task automatic refresh();
        bus.ref_clk = 1'b1;
        step();
        bus.ref_clk = 1'b0;
    endtask

    // One increment followed by the guaranteed quiet window
    task automatic do_inc(input logic [5:0] trig);
        strobe_inc(trig);
        repeat (16) step();
        check("idle_after_inc", 32'(bus.busy), 32'd0);
    endtask

    initial begin
        int n;
        n_cmp = 0;
        n_err = 0;
        bus.trigger = '0;
        bus.inc_clk = 1'b0;
        bus.ref_clk = 1'b0;
        reset       = 1'b1;

        vecs[0] = '{6'b000001, 24'h000001};
        vecs[1] = '{6'b000010, 24'h000011};
        vecs[2] = '{6'b111111, 24'h111122};
        vecs[3] = '{6'b000000, 24'h111122};
        vecs[4] = '{6'b101010, 24'h212132};
        vecs[5] = '{6'b010101, 24'h222233};

        step();
        step();
        reset = 1'b0;
        step();
        check("reset_count_out", 32'(bus.count_out), 32'h0);
        check("reset_busy", 32'(bus.busy), 32'd0);
        check("reset_overflow", 32'(bus.overflow), 32'd0);

        // Busy window and first increment
        strobe_inc(6'b000001);
        n = 0;
        while (bus.busy && n < 20) begin
            n++;
            step();
        end
        check("busy_cycles", 32'(n), 32'd6);
        check("no_refresh_no_change", 32'(bus.count_out), 32'h0);
        repeat (10) step();
        refresh();
        check("first_inc", 32'(bus.count_out), 32'h000001);
        check("first_inc_ovf", 32'(bus.overflow), 32'd0);

        // Table of increment patterns from a clean start
        do_reset();
        for (int i = 0; i < 6; i++) begin
            do_inc(vecs[i].trig);
            refresh();
            check($sformatf("vec%0d_count", i), 32'(bus.count_out), 32'(vecs[i].exp_count));
            check($sformatf("vec%0d_ovf", i), 32'(bus.overflow), 32'd0);
        end

        // 9 -> 10 -> 21
        do_reset();
        repeat (9) do_inc(6'b000001);
        do_inc(6'b000001);
        refresh();
        check("carry_9_to_10", 32'(bus.count_out), 32'h000010);
        do_inc(6'b000011);
        refresh();
        check("inc_to_21", 32'(bus.count_out), 32'h000021);

        // 99 + 11 with incoming carry on digit 1
        do_reset();
        repeat (9) do_inc(6'b000011);
        refresh();
        check("preload_99", 32'(bus.count_out), 32'h000099);
        do_inc(6'b000011);
        refresh();
        check("carry_chain_110", 32'(bus.count_out), 32'h000110);

        // Wrap and sticky overflow
        do_reset();
        repeat (9) do_inc(6'b111111);
        refresh();
        check("preload_999999", 32'(bus.count_out), 32'h999999);
        check("preload_ovf", 32'(bus.overflow), 32'd0);
        do_inc(6'b000001);
        refresh();
        check("wrap_count", 32'(bus.count_out), 32'h000000);
        check("wrap_ovf", 32'(bus.overflow), 32'd1);
        do_inc(6'b000001);
        refresh();
        check("after_wrap_count", 32'(bus.count_out), 32'h000001);
        check("ovf_sticky", 32'(bus.overflow), 32'd1);

        // Refresh mid-ripple is deferred; inc_clk while busy is ignored
        strobe_inc(6'b000001);
        step();
        bus.ref_clk = 1'b1;
        step();
        bus.ref_clk = 1'b0;
        bus.trigger = 6'b111111;
        bus.inc_clk = 1'b1;
        step();
        bus.inc_clk = 1'b0;
        n = 0;
        while (bus.busy && n < 20) begin
            if (bus.count_out !== 24'h000001) begin
                check("hold_during_ripple", 32'(bus.count_out), 32'h000001);
            end
            n++;
            step();
        end
        check("deferred_busy_end", 32'(bus.busy), 32'd0);
        check("deferred_not_yet", 32'(bus.count_out), 32'h000001);
        step();
        check("deferred_load", 32'(bus.count_out), 32'h000002);
        repeat (16) step();
        check("busy_inc_ignored_busy", 32'(bus.busy), 32'd0);
        check("deferred_once", 32'(bus.count_out), 32'h000002);
        refresh();
        check("busy_inc_ignored_count", 32'(bus.count_out), 32'h000002);

        // Reset during ripple cycle 3 aborts everything
        strobe_inc(6'b000001);
        step();
        step();
        reset = 1'b1;
        #1;
        check("midreset_count_out", 32'(bus.count_out), 32'h0);
        check("midreset_busy", 32'(bus.busy), 32'd0);
        check("midreset_ovf", 32'(bus.overflow), 32'd0);
        step();
        reset = 1'b0;
        step();
        do_inc(6'b000001);
        refresh();
        check("post_reset_inc", 32'(bus.count_out), 32'h000001);

        // ref_clk and inc_clk together: display takes the pre-increment value
        bus.ref_clk = 1'b1;
        strobe_inc(6'b000001);
        bus.ref_clk = 1'b0;
        check("same_cycle_pre_inc", 32'(bus.count_out), 32'h000001);
        check("same_cycle_busy", 32'(bus.busy), 32'd1);
        repeat (16) step();
        refresh();
        check("same_cycle_post", 32'(bus.count_out), 32'h000002);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
